// File: rtl/aes_pkg.sv
// Shared definitions for the round-key sequencer slice.
//   - Round-key counts for AES-128/192/256.
//   - Default round-key width.
//   - Sequencer FSM state type.
//   - Legality check for a requested round-key count.
package aes_pkg;

    localparam int unsigned KEY_W_DEFAULT = 128;

    localparam logic [4:0] NK_128 = 5'd11;
    localparam logic [4:0] NK_192 = 5'd13;
    localparam logic [4:0] NK_256 = 5'd15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FINISH
    } state_e;

    function automatic logic is_legal_num_keys(input logic [4:0] nk);
        return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
    endfunction

endpackage

// File: rtl/round_key_mux.sv
// Combinational selection of one round key from the expanded-key bus.
// Ports:
//   key_exp_i  expanded key; key 0 sits in the most-significant KEY_W bits
//   idx_i      round index to select
//   key_o      selected round key (zero for an index beyond MAX_KEYS-1)
module round_key_mux #(
    parameter int unsigned KEY_W    = 128,
    parameter int unsigned MAX_KEYS = 15,
    parameter int unsigned IDX_W    = 4
) (
    input  logic [KEY_W*MAX_KEYS-1:0] key_exp_i,
    input  logic [IDX_W-1:0]          idx_i,
    output logic [KEY_W-1:0]          key_o
);

    always_comb begin
        key_o = '0;
        for (int unsigned k = 0; k < MAX_KEYS; k++) begin
            if (idx_i == IDX_W'(k)) begin
                key_o = key_exp_i[(MAX_KEYS-1-k)*KEY_W +: KEY_W];
            end
        end
    end

endmodule

// File: rtl/round_key_sequencer.sv
// Walks the expanded key schedule and hands out one round key per
// valid/ready handshake, in forward or inverse order, for 11/13/15 keys.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   start          one-cycle request to begin a sequence
//   inverse        0 = key 0 first, 1 = last key first
//   num_keys       keys in the sequence (11, 13 or 15)
//   key_exp        expanded key bus, held stable for the whole sequence
//   abort          synchronous cancel
//   key_ready      consumer accepts the current key
//   round_key      registered current key
//   round_idx      index of round_key within key_exp
//   key_valid      round_key/round_idx valid
//   last_key       final key of the sequence is being offered
//   busy           sequence in progress
//   done           one-cycle pulse after the final key is accepted
//   err            one-cycle pulse for a start with an illegal num_keys
module round_key_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned KEY_W    = KEY_W_DEFAULT,
    parameter int unsigned MAX_KEYS = 15,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      inverse,
    input  logic [4:0]                num_keys,
    input  logic [KEY_W*MAX_KEYS-1:0] key_exp,
    input  logic                      abort,
    input  logic                      key_ready,
    output logic [KEY_W-1:0]          round_key,
    output logic [IDX_W-1:0]          round_idx,
    output logic                      key_valid,
    output logic                      last_key,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4:0]         nk_q, nk_d;
    logic               inv_q, inv_d;
    logic               err_q, err_d;
    logic [KEY_W-1:0]   round_key_q;
    logic [KEY_W-1:0]   slice;
    logic               legal;
    logic               at_last;

    assign legal   = is_legal_num_keys(num_keys) && (32'(num_keys) <= MAX_KEYS);
    assign at_last = inv_q ? (idx_q == '0) : (idx_q == IDX_W'(nk_q - 5'd1));

    // The mux looks at the next index so round_key is registered already
    // pointing at the key that will be offered in the following cycle.
    round_key_mux #(
        .KEY_W    (KEY_W),
        .MAX_KEYS (MAX_KEYS),
        .IDX_W    (IDX_W)
    ) u_mux (
        .key_exp_i (key_exp),
        .idx_i     (idx_d),
        .key_o     (slice)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nk_d    = nk_q;
        inv_d   = inv_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort outranks start, and suppresses err as well
                if (!abort && start) begin
                    if (legal) begin
                        state_d = ISSUE;
                        nk_d    = num_keys;
                        inv_d   = inverse;
                        idx_d   = inverse ? IDX_W'(num_keys - 5'd1) : '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (key_ready) begin
                    if (at_last) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = inv_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            nk_q        <= '0;
            inv_q       <= 1'b0;
            err_q       <= 1'b0;
            round_key_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nk_q    <= nk_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
            if (state_d == ISSUE) begin
                round_key_q <= slice;
            end
        end
    end

    assign round_key = round_key_q;
    assign round_idx = idx_q;
    assign key_valid = (state_q == ISSUE);
    assign busy      = (state_q == ISSUE);
    assign last_key  = (state_q == ISSUE) && at_last;
    assign done      = (state_q == FINISH);
    assign err       = err_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
module tb_round_key_sequencer;

    localparam int unsigned KEY_W    = 128;
    localparam int unsigned MAX_KEYS = 15;
    localparam int unsigned IDX_W    = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      start = 1'b0;
    logic                      inverse = 1'b0;
    logic [4:0]                num_keys = '0;
    logic [KEY_W*MAX_KEYS-1:0] key_exp = '0;
    logic                      abort = 1'b0;
    logic                      key_ready = 1'b0;
    logic [KEY_W-1:0]          round_key;
    logic [IDX_W-1:0]          round_idx;
    logic                      key_valid, last_key, busy, done, err;

    logic [KEY_W-1:0] keys [MAX_KEYS];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    round_key_sequencer #(
        .KEY_W    (KEY_W),
        .MAX_KEYS (MAX_KEYS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inverse   (inverse),
        .num_keys  (num_keys),
        .key_exp   (key_exp),
        .abort     (abort),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .last_key  (last_key),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Builds key_exp by shifting keys in from the LSB end, so key 0 ends
    // up in the most-significant slot.
    task automatic load_keys(input bit pattern);
        key_exp = '0;
        for (int k = 0; k < int'(MAX_KEYS); k++) begin
            if (pattern) keys[k] = {16{8'(k)}};
            else         keys[k] = {$urandom, $urandom, $urandom, $urandom};
            key_exp = (key_exp << KEY_W) | {{(KEY_W*(MAX_KEYS-1)){1'b0}}, keys[k]};
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if ({round_key, round_idx, key_valid, last_key, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_state: key=%h idx=%0d valid=%b last=%b busy=%b done=%b err=%b, need all 0",
                     round_key, round_idx, key_valid, last_key, busy, done, err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_inverse_128();
        int e;
        load_keys(1'b1);
        @(negedge clk);
        start = 1'b1; inverse = 1'b1; num_keys = 5'd11; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 11; n++) begin
            e = 10 - n;
            checks++;
            if ({key_valid, busy, last_key, round_idx, round_key} !==
                {1'b1, 1'b1, (e == 0), IDX_W'(e), keys[e]}) begin
                failures++;
                $display("FAIL inv128_key%0d: valid=%b busy=%b last=%b idx=%0d key=%h, need 1 1 %b %0d %h",
                         n, key_valid, busy, last_key, round_idx, round_key, (e == 0), e, keys[e]);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, key_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL inv128_done: done=%b valid=%b busy=%b, need 1 0 0", done, key_valid, busy);
        end
        // start arriving while in FINISH must be ignored
        start = 1'b1; inverse = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, key_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL inv128_finish_start: done=%b valid=%b busy=%b, need 0 0 0", done, key_valid, busy);
        end
    endtask

    task automatic test_forward_256_busy_start();
        load_keys(1'b0);
        @(negedge clk);
        start = 1'b1; inverse = 1'b0; num_keys = 5'd15; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 15; n++) begin
            checks++;
            if ({key_valid, busy, last_key, round_idx, round_key} !==
                {1'b1, 1'b1, (n == 14), IDX_W'(n), keys[n]}) begin
                failures++;
                $display("FAIL fwd256_key%0d: valid=%b last=%b idx=%0d key=%h, need 1 %b %0d %h",
                         n, key_valid, last_key, round_idx, round_key, (n == 14), n, keys[n]);
            end
            if (n == 14) begin
                checks++;
                if (round_key !== key_exp[KEY_W-1:0]) begin
                    failures++;
                    $display("FAIL fwd256_lsb_key: key=%h, need %h", round_key, key_exp[KEY_W-1:0]);
                end
            end
            // a start while busy must not disturb the running sequence
            if (n == 5) begin start = 1'b1; inverse = 1'b1; num_keys = 5'd11; end
            else        start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({done, key_valid} !== 2'b10) begin
            failures++;
            $display("FAIL fwd256_done: done=%b valid=%b, need 1 0", done, key_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_ready_stall_192();
        int e;
        int xfers;
        int cyc;
        bit r;
        load_keys(1'b0);
        @(negedge clk);
        start = 1'b1; inverse = 1'b1; num_keys = 5'd13; key_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        e = 12; xfers = 0; cyc = 0;
        while (xfers < 13 && cyc < 300) begin
            checks++;
            if ({key_valid, last_key, round_idx, round_key} !==
                {1'b1, (e == 0), IDX_W'(e), keys[e]}) begin
                failures++;
                $display("FAIL stall192_cyc%0d: valid=%b last=%b idx=%0d key=%h, need 1 %b %0d %h",
                         cyc, key_valid, last_key, round_idx, round_key, (e == 0), e, keys[e]);
            end
            r = 1'($urandom_range(0, 1));
            key_ready = r;
            @(negedge clk);
            cyc++;
            if (r) begin xfers++; e--; end
        end
        checks++;
        if (xfers != 13 || {done, key_valid} !== 2'b10) begin
            failures++;
            $display("FAIL stall192_end: xfers=%0d done=%b valid=%b, need 13 1 0", xfers, done, key_valid);
        end
        key_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal_num_keys();
        logic [4:0] bad [3];
        bad[0] = 5'd12;
        for (int i = 1; i < 3; i++) begin
            do bad[i] = 5'($urandom_range(0, 31));
            while (bad[i] == 5'd11 || bad[i] == 5'd13 || bad[i] == 5'd15);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; num_keys = bad[i]; inverse = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({err, key_valid, busy, done} !== 4'b1000) begin
                failures++;
                $display("FAIL illegal_nk%0d: err=%b valid=%b busy=%b done=%b, need 1 0 0 0",
                         bad[i], err, key_valid, busy, done);
            end
            @(negedge clk);
            checks++;
            if ({err, key_valid, busy} !== 3'b000) begin
                failures++;
                $display("FAIL illegal_after%0d: err=%b valid=%b busy=%b, need 0 0 0", bad[i], err, key_valid, busy);
            end
        end
        load_keys(1'b0);
        start = 1'b1; inverse = 1'b0; num_keys = 5'd11; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 11; n++) begin
            checks++;
            if ({key_valid, err, round_idx, round_key} !== {1'b1, 1'b0, IDX_W'(n), keys[n]}) begin
                failures++;
                $display("FAIL legal_after_err%0d: valid=%b err=%b idx=%0d key=%h, need 1 0 %0d %h",
                         n, key_valid, err, round_idx, round_key, n, keys[n]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL legal_after_err_done: done=%b, need 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        load_keys(1'b0);
        @(negedge clk);
        start = 1'b1; inverse = 1'b0; num_keys = 5'd11; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if ({key_valid, round_idx, round_key} !== {1'b1, IDX_W'(n), keys[n]}) begin
                failures++;
                $display("FAIL abort_pre%0d: valid=%b idx=%0d, need 1 %0d", n, key_valid, round_idx, n);
            end
            if (n == 3) begin abort = 1'b1; key_ready = 1'b0; end
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if ({key_valid, busy, last_key, done} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_clear: valid=%b busy=%b last=%b done=%b, need 0 0 0 0",
                     key_valid, busy, last_key, done);
        end
        @(negedge clk);
        checks++;
        if ({done, key_valid} !== 2'b00) begin
            failures++;
            $display("FAIL abort_no_done: done=%b valid=%b, need 0 0", done, key_valid);
        end
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checks++;
        if ({key_valid, busy, err} !== 3'b000) begin
            failures++;
            $display("FAIL abort_beats_start: valid=%b busy=%b err=%b, need 0 0 0", key_valid, busy, err);
        end
        start = 1'b1; inverse = 1'b1; num_keys = 5'd11; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 11; n++) begin
            checks++;
            if ({key_valid, round_idx, round_key} !== {1'b1, IDX_W'(10 - n), keys[10 - n]}) begin
                failures++;
                $display("FAIL abort_restart%0d: valid=%b idx=%0d, need 1 %0d", n, key_valid, round_idx, 10 - n);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart_done: done=%b, need 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        load_keys(1'b0);
        @(negedge clk);
        start = 1'b1; inverse = 1'b0; num_keys = 5'd15; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({key_valid, round_idx} !== {1'b1, IDX_W'(1)}) begin
            failures++;
            $display("FAIL rst_pre: valid=%b idx=%0d, need 1 1", key_valid, round_idx);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({round_key, round_idx, key_valid, last_key, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL rst_async: key=%h idx=%0d valid=%b last=%b busy=%b done=%b err=%b, need all 0",
                     round_key, round_idx, key_valid, last_key, busy, done, err);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++;
            if ({done, key_valid, busy} !== 3'b000) begin
                failures++;
                $display("FAIL rst_after%0d: done=%b valid=%b busy=%b, need 0 0 0", n, done, key_valid, busy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_inverse_128();
        test_forward_256_busy_start();
        test_ready_stall_192();
        test_illegal_num_keys();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Parametrised, fully synchronous successor to the inverse-only key controller.
- Walks the expanded key schedule and issues one round key per valid/ready handshake.
- Supports forward (encrypt) and inverse (decrypt) order, and AES-128/192/256 key-count modes.
- Sits between the key-expansion block and the round datapath; replaces delay-based, edge-triggered key selection with a clocked FSM.

Parameters:
- KEY_W, 128, width of one round key in bits.
- MAX_KEYS, 15, maximum round keys held in the expanded-key bus (AES-256).
- IDX_W, 4, width of round index; must satisfy 2**IDX_W >= MAX_KEYS.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a key sequence.
- inverse  in  1  0 = forward order (key 0 first); 1 = inverse order (last key first).
- num_keys  in  5  round keys in this sequence; legal values are 11, 13 and 15.
- key_exp  in  KEY_W*MAX_KEYS  expanded key; key k occupies bits [k*KEY_W +: KEY_W] counted from the MSB end (key 0 = most-significant KEY_W bits).
- abort  in  1  synchronous cancel of the current sequence.
- key_ready  in  1  consumer accepts round_key this cycle.
- round_key  out  KEY_W  current round key, registered.
- round_idx  out  IDX_W  index of round_key within key_exp.
- key_valid  out  1  round_key/round_idx are valid.
- last_key  out  1  high together with key_valid on the final key of the sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the final key is accepted.
- err  out  1  one-cycle pulse when start is given with an illegal num_keys.

Behaviour:
- Reset (rst=0, async): state=IDLE; round_key=0, round_idx=0, key_valid=0, last_key=0, busy=0, done=0, err=0. A reset mid-sequence drops the sequence with no done pulse.
- FSM states: IDLE, ISSUE, FINISH.
- IDLE:
  - start=1 with legal num_keys: latch num_keys and inverse; first idx = 0 (forward) or num_keys-1 (inverse); go to ISSUE.
  - start=1 with illegal num_keys: err=1 for one cycle; stay in IDLE; busy stays 0.
  - start=0: stay in IDLE.
- ISSUE:
  - On the cycle after start: key_valid=1, busy=1, round_key=key_exp slice[idx], round_idx=idx. Latency is 1 clock from start to the first valid key.
  - Handshake: a transfer occurs when key_valid & key_ready. On transfer, idx moves by +1 (forward) or -1 (inverse); round_key is re-registered from the new slice on the next clock.
  - Back-to-back transfers give one key per clock.
  - key_valid=1 with key_ready=0: round_key, round_idx and last_key hold stable.
  - last_key=1 when idx = num_keys-1 (forward) or idx = 0 (inverse).
  - Transfer while last_key=1: go to FINISH with key_valid=0. The index never wraps past either end.
- FINISH: done=1 for exactly one cycle; busy=0; return to IDLE. A start that arrives in FINISH is ignored.
- start while busy: ignored; latched mode and num_keys are unaffected.
- abort (synchronous, highest priority after reset):
  - In ISSUE: clear key_valid, last_key and busy; go to IDLE next cycle; no done pulse.
  - abort and start in the same cycle in IDLE: abort wins and start is ignored.
- key_exp must stay stable from start until done or abort. The block does not register the full bus, only the selected slice.
- Slice select is a dynamic part-select, or a mux over MAX_KEYS entries. Index arithmetic uses IDX_W bits, unsigned.

Decomposition:
- Shared package aes_pkg holds:
  - constants NK_128=11, NK_192=13, NK_256=15;
  - KEY_W default;
  - FSM state enum (IDLE/ISSUE/FINISH);
  - function is_legal_num_keys().
- One natural sub-module: round_key_mux (combinational key_exp slice select by index), reused by the forward key controller.

Test Plan:
- Reset, then start with num_keys=11, inverse=1, key_ready held 1, key k = {16{8'hk}} -> round_idx 10,9,...,0 on consecutive cycles; first valid 1 clk after start; last_key with idx 0; done pulses 1 clk after that.
- start with num_keys=15, inverse=0, key_ready=1 -> idx 0..14 in order; round_key for idx 14 = key_exp LSB 128 bits; exactly 15 transfers, then done.
- num_keys=13, inverse=1, key_ready toggling 1,0,0,1,... -> idx 12 first; round_key/round_idx stable during ready=0 cycles; 13 transfers total; no skipped or duplicated index.
- start with num_keys=12 -> err pulses 1 clk; key_valid, busy and done stay 0; a following legal start (11) runs normally.
- abort asserted after 3 transfers (AES-128, forward) -> key_valid=0 next clk, no done; a new start with inverse=1 begins at idx 10. A start while busy is ignored, and idx continues uninterrupted.
- rst pulled low mid-sequence with key_valid=1 -> all outputs 0 asynchronously (before the next clk edge); no done after rst release.
